// File: rtl/muldiv_sequencer.sv
// Multi-cycle MUL/DIV sequencer beside the single-cycle ALU: shift-add multiply
// (low word) and signed restoring divide, stalling the pipeline while it iterates.
module muldiv_sequencer #(
  parameter int         WIDTH   = 32,
  parameter logic [4:0] ALU_MUL = 5'd10,
  parameter logic [4:0] ALU_DIV = 5'd12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       alu_op,
  input  logic             flush,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             stall,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] result
);

  localparam int               CW         = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_INT    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    LAST_COUNT = CW'(WIDTH-1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CW-1:0]    count;
  logic             op_div, neg_q;
  logic [WIDTH-1:0] reg_a, reg_b, acc, rem;

  logic             is_muldiv, is_div, accept;
  logic             div_zero, div_ovf, div_special;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   rem_shift, diff;
  logic             q_bit;
  logic [WIDTH-1:0] acc_step, final_value;

  // reg_a is the multiplicand (MUL) or the dividend being shifted out MSB first (DIV);
  // reg_b is the multiplier or |divisor|; acc is the product or the quotient.
  always_comb begin
    is_div      = (alu_op == ALU_DIV);
    is_muldiv   = (alu_op == ALU_MUL) || is_div;
    accept      = start & is_muldiv & ~flush & ~reset & (state == IDLE);
    div_zero    = (operand_b == '0);
    div_ovf     = (operand_a == MIN_INT) && (operand_b == '1);
    div_special = is_div & (div_zero | div_ovf);
    abs_a       = operand_a[WIDTH-1] ? -operand_a : operand_a;
    abs_b       = operand_b[WIDTH-1] ? -operand_b : operand_b;
    rem_shift   = {rem, reg_a[WIDTH-1]};
    diff        = rem_shift - {1'b0, reg_b};
    q_bit       = ~diff[WIDTH];
    acc_step    = op_div ? {acc[WIDTH-2:0], q_bit}
                         : (reg_b[0] ? acc + reg_a : acc);
    final_value = (op_div && neg_q) ? -acc_step : acc_step;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = div_special ? DONE : CALC;
      CALC: begin
        if (flush)              state_next = IDLE;
        else if (count == '0)   state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    stall        = accept | (state == CALC);
    result_valid = (state == DONE) & ~flush;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      op_div <= 1'b0;
      neg_q  <= 1'b0;
      reg_a  <= '0;
      reg_b  <= '0;
      acc    <= '0;
      rem    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_div <= is_div;
            count  <= LAST_COUNT;
            acc    <= '0;
            rem    <= '0;
            if (is_div) begin
              reg_a <= abs_a;
              reg_b <= abs_b;
              neg_q <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
            end else begin
              reg_a <= operand_a;
              reg_b <= operand_b;
              neg_q <= 1'b0;
            end
            // Special-case divides skip CALC, so their result is loaded here.
            if (div_special) result <= div_zero ? '1 : operand_a;
          end
        end
        CALC: begin
          acc   <= acc_step;
          reg_a <= reg_a << 1;
          count <= count - 1'b1;
          if (op_div) rem   <= q_bit ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
          else        reg_b <= reg_b >> 1;
          // The final iteration's value goes straight into result so it is valid in DONE.
          if (count == '0 && !flush) result <= final_value;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed vector table, hand-written flush/reset/back-to-back
// sequences, and random MUL/DIV checked against an arithmetic reference model.
module tb_muldiv_sequencer;

  localparam int         W   = 32;
  localparam logic [4:0] MUL = 5'd10;
  localparam logic [4:0] DIV = 5'd12;
  localparam logic [4:0] ADD = 5'd0;

  logic         clk = 1'b0;
  logic         reset;
  logic         start = 1'b0;
  logic [4:0]   alu_op = ADD;
  logic         flush = 1'b0;
  logic [W-1:0] operand_a = '0;
  logic [W-1:0] operand_b = '0;
  logic         stall, busy, result_valid;
  logic [W-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_result = '0;

  muldiv_sequencer #(.WIDTH(W), .ALU_MUL(MUL), .ALU_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .start(start), .alu_op(alu_op), .flush(flush),
    .operand_a(operand_a), .operand_b(operand_b),
    .stall(stall), .busy(busy), .result_valid(result_valid), .result(result)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_model(input logic [4:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [63:0] p;
    longint      sa, sb, q;
    if (op == MUL) begin
      p = {32'b0, a} * {32'b0, b};
      return p[W-1:0];
    end
    if (b == '0) return '1;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    return q[W-1:0];
  endfunction

  function automatic int ref_latency(input logic [4:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
    if (op == DIV && (b == '0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return W + 1;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Presents one MUL/DIV from cycle 0 and keeps presenting it through DONE; returns in
  // the DONE cycle (or after a cycle budget) so the caller may drive the next cycle.
  task automatic run_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp, input int exp_lat, input string name);
    int cyc;
    int stall_cycles;
    bit got;
    logic [W-1:0] want;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    start = 1'b1; alu_op = op; operand_a = a; operand_b = b;
    @(negedge clk);
    chk({name, "_accept_stall"}, W'(stall), W'(1));
    chk({name, "_accept_busy"}, W'(busy), W'(0));
    chk({name, "_accept_rv"}, W'(result_valid), W'(0));
    stall_cycles = 1; cyc = 0; got = 0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (result_valid) got = 1;
      else if (stall) stall_cycles++;
    end
    chk({name, "_latency"}, W'(cyc), W'(exp_lat));
    chk({name, "_stall_cycles"}, W'(stall_cycles), W'(exp_lat));
    chk({name, "_done_stall"}, W'(stall), W'(0));
    chk({name, "_done_busy"}, W'(busy), W'(1));
    want = exp_q.pop_front();
    chk({name, "_result"}, result, want);
    last_result = want;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    start = 1'b0; alu_op = ADD;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int pulses;
    logic [4:0]   op;
    logic [W-1:0] a, b;

    vecs[0]  = '{MUL, 32'd7,          32'd6,          32'd42,         33};
    vecs[1]  = '{MUL, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  33};
    vecs[2]  = '{DIV, 32'hFFFF_FFEC,  32'd3,          32'hFFFF_FFFA,  33};
    vecs[3]  = '{DIV, 32'd20,         32'hFFFF_FFFD,  32'hFFFF_FFFA,  33};
    vecs[4]  = '{DIV, 32'h7FFF_FFFF,  32'd1,          32'h7FFF_FFFF,  33};
    vecs[5]  = '{DIV, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[6]  = '{DIV, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    vecs[7]  = '{DIV, 32'd100,        32'd7,          32'd14,         33};
    vecs[8]  = '{DIV, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          33};
    vecs[9]  = '{MUL, 32'h8000_0000,  32'd2,          32'd0,          33};
    vecs[10] = '{DIV, 32'h8000_0000,  32'd1,          32'h8000_0000,  33};
    vecs[11] = '{DIV, 32'd3,          32'd7,          32'd0,          33};
    vecs[12] = '{MUL, 32'h1234_5678,  32'h10,         32'h2345_6780,  33};

    // Reset state
    reset = 1'b1;
    #7;
    chk("reset_stall", W'(stall), W'(0));
    chk("reset_busy", W'(busy), W'(0));
    chk("reset_rv", W'(result_valid), W'(0));
    chk("reset_result", result, '0);
    #15 reset = 1'b0;

    // Directed table, issued back to back
    for (int i = 0; i < 13; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));

    // Non-MUL/DIV op is ignored
    @(posedge clk); #1;
    start = 1'b1; alu_op = ADD; operand_a = 32'd9; operand_b = 32'd9;
    @(negedge clk);
    chk("add_no_stall", W'(stall), W'(0));
    @(negedge clk);
    chk("add_no_busy", W'(busy), W'(0));
    chk("add_result_held", result, last_result);

    // Flush in cycle 10 of a MUL, with the MUL still presented under flush
    @(posedge clk); #1;
    start = 1'b1; alu_op = MUL; operand_a = 32'd3; operand_b = 32'd5;
    pulses = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 10) flush = 1'b1;
      @(negedge clk);
      if (result_valid) pulses++;
    end
    chk("flush_c10_stall", W'(stall), W'(1));
    @(posedge clk); #1;
    @(negedge clk);
    chk("flush_idle_stall", W'(stall), W'(0));
    chk("flush_idle_busy", W'(busy), W'(0));
    chk("flush_idle_rv", W'(result_valid), W'(0));
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0; alu_op = ADD;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (result_valid) pulses++;
    end
    chk("flush_no_pulse", W'(pulses), W'(0));
    chk("flush_result_held", result, last_result);

    // Asynchronous reset mid-CALC, MUL still presented during reset
    @(posedge clk); #1;
    start = 1'b1; alu_op = MUL; operand_a = 32'd11; operand_b = 32'd13;
    repeat (5) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("areset_stall", W'(stall), W'(0));
    chk("areset_busy", W'(busy), W'(0));
    chk("areset_rv", W'(result_valid), W'(0));
    chk("areset_result", result, '0);
    last_result = '0;
    @(posedge clk); #3;
    reset = 1'b0; start = 1'b0; alu_op = ADD;
    @(negedge clk);
    chk("areset_after_busy", W'(busy), W'(0));

    // Stalled DIV held through DONE, then a new MUL accepted in the following cycle
    run_op(DIV, 32'd1000, 32'd10, 32'd100, 33, "hold_div");
    run_op(MUL, 32'd9, 32'd9, 32'd81, 33, "next_mul");

    // Randomized MUL/DIV against the reference model
    for (int i = 0; i < 30; i++) begin
      op = ($urandom_range(0, 1) == 0) ? MUL : DIV;
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 200); b = $urandom_range(1, 20); end
        3: b = $urandom_range(0, 3) - 32'd2;
        default: ;
      endcase
      run_op(op, a, b, ref_model(op, a, b), ref_latency(op, a, b), $sformatf("rand%0d", i));
      repeat ($urandom_range(0, 2)) idle_cycle();
    end

    idle_cycle();
    chk("end_queue_empty", W'(exp_q.size()), W'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
